// File: rtl/data_mem_read_sched_if.sv
// Handshake bundle between the layer controller / data memory and the read scheduler.
// The slave modport is the scheduler's side; the master modport is the controller/memory side.
interface data_mem_read_sched_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        num_rows;
    logic              scan_mode;
    logic              rd_ready;
    logic [ADDR_W-1:0] addr_1_out;
    logic [ADDR_W-1:0] addr_2_out;
    logic              addr_1_valid_out;
    logic              addr_2_valid_out;
    logic [7:0]        tile_idx_out;
    logic [7:0]        phase_out;
    logic              tile_last_out;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport slave (
        input  start, base_addr, num_rows, scan_mode, rd_ready,
        output addr_1_out, addr_2_out, addr_1_valid_out, addr_2_valid_out,
               tile_idx_out, phase_out, tile_last_out, busy, done, cfg_err
    );

    modport master (
        output start, base_addr, num_rows, scan_mode, rd_ready,
        input  addr_1_out, addr_2_out, addr_1_valid_out, addr_2_valid_out,
               tile_idx_out, phase_out, tile_last_out, busy, done, cfg_err
    );
endinterface

// File: rtl/data_mem_read_sched.sv
// Read-address scheduler for the dual-port input data memory: walks a column of
// Winograd tiles, issuing an even/odd row pair per accepted cycle.
module data_mem_read_sched #(
    parameter int ADDR_W    = 8,
    parameter int TILE_ROWS = 4,
    parameter int STRIDE    = 2
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_read_sched_if.slave bus
);
    localparam int                NP         = TILE_ROWS / 2;
    localparam logic [7:0]        LAST_PHASE = 8'(NP - 1);
    localparam logic [ADDR_W-1:0] PAIR_STEP  = ADDR_W'(2);
    // Moving from the last phase of one tile to phase 0 of the next; may be negative, wraps mod 2^ADDR_W.
    localparam logic [ADDR_W-1:0] TILE_STEP  = ADDR_W'(STRIDE - 2 * (NP - 1));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic [7:0]        tile_q, tile_d;
    logic [7:0]        phase_q, phase_d;
    logic [7:0]        last_tile_q, last_tile_d;
    logic              cfg_err_q, cfg_err_d;

    logic valid;
    logic accept;
    logic last_pair;

    // Valid is the only combinational output: scan-load must gate it within the same cycle.
    assign valid     = (state_q == S_RUN) && !bus.scan_mode;
    assign accept    = valid && bus.rd_ready;
    assign last_pair = (tile_q == last_tile_q) && (phase_q == LAST_PHASE);

    always_comb begin
        // NOTE: every next-state signal takes a hold/default value first so no path infers a latch.
        state_d     = state_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        tile_d      = tile_q;
        phase_d     = phase_q;
        last_tile_d = last_tile_q;
        cfg_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.scan_mode) begin
                    if (bus.num_rows >= 8'(TILE_ROWS)) begin
                        addr1_d     = bus.base_addr;
                        addr2_d     = bus.base_addr + ADDR_W'(1);
                        tile_d      = 8'd0;
                        phase_d     = 8'd0;
                        last_tile_d = (bus.num_rows - 8'(TILE_ROWS)) / 8'(STRIDE);
                        state_d     = S_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (last_pair) begin
                        addr1_d = '0;
                        addr2_d = '0;
                        tile_d  = 8'd0;
                        phase_d = 8'd0;
                        state_d = S_DONE;
                    end else if (phase_q != LAST_PHASE) begin
                        phase_d = phase_q + 8'd1;
                        addr1_d = addr1_q + PAIR_STEP;
                        addr2_d = addr2_q + PAIR_STEP;
                    end else begin
                        phase_d = 8'd0;
                        tile_d  = tile_q + 8'd1;
                        addr1_d = addr1_q + TILE_STEP;
                        addr2_d = addr2_q + TILE_STEP;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr1_q     <= '0;
            addr2_q     <= '0;
            tile_q      <= 8'd0;
            phase_q     <= 8'd0;
            last_tile_q <= 8'd0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            tile_q      <= tile_d;
            phase_q     <= phase_d;
            last_tile_q <= last_tile_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign bus.addr_1_out       = addr1_q;
    assign bus.addr_2_out       = addr2_q;
    assign bus.addr_1_valid_out = valid;
    assign bus.addr_2_valid_out = valid;
    assign bus.tile_idx_out     = tile_q;
    assign bus.phase_out        = phase_q;
    assign bus.tile_last_out    = valid && last_pair;
    assign bus.busy             = (state_q == S_RUN);
    assign bus.done             = (state_q == S_DONE);
    assign bus.cfg_err          = cfg_err_q;
endmodule

// File: tb/tb_data_mem_read_sched.sv
// Directed bench for data_mem_read_sched: expected address pairs are queued at start
// and popped as the scheduler presents them.
module tb_data_mem_read_sched;
    localparam int ADDR_W    = 8;
    localparam int TILE_ROWS = 4;
    localparam int STRIDE    = 2;
    localparam int NP        = TILE_ROWS / 2;

    typedef struct {
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] tile;
        logic [7:0] phase;
        logic       last;
    } pair_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    pair_t exp_q[$];

    data_mem_read_sched_if #(.ADDR_W(ADDR_W)) bus ();

    data_mem_read_sched #(
        .ADDR_W   (ADDR_W),
        .TILE_ROWS(TILE_ROWS),
        .STRIDE   (STRIDE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: row r = base + tile*STRIDE + 2*phase, computed directly per pair.
    function automatic void push_seq(input logic [7:0] base, input logic [7:0] nrows);
        int nt;
        pair_t e;
        nt = (int'(nrows) - TILE_ROWS) / STRIDE + 1;
        for (int t = 0; t < nt; t++) begin
            for (int p = 0; p < NP; p++) begin
                e.a1    = base + 8'(t * STRIDE + 2 * p);
                e.a2    = e.a1 + 8'd1;
                e.tile  = 8'(t);
                e.phase = 8'(p);
                e.last  = (t == nt - 1) && (p == NP - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_a1"},    32'(bus.addr_1_out), 32'd0);
        check({tag, "_a2"},    32'(bus.addr_2_out), 32'd0);
        check({tag, "_v1"},    32'(bus.addr_1_valid_out), 32'd0);
        check({tag, "_v2"},    32'(bus.addr_2_valid_out), 32'd0);
        check({tag, "_tile"},  32'(bus.tile_idx_out), 32'd0);
        check({tag, "_phase"}, 32'(bus.phase_out), 32'd0);
        check({tag, "_last"},  32'(bus.tile_last_out), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_cfg"},   32'(bus.cfg_err), 32'd0);
    endtask

    task automatic do_start(input logic [7:0] base, input logic [7:0] nrows, input logic scan);
        @(posedge clk);
        #2;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_rows  = nrows;
        bus.scan_mode = scan;
        bus.rd_ready  = 1'b1;
        #1;
        if (!scan && nrows >= 8'(TILE_ROWS)) push_seq(base, nrows);
    endtask

    // One clock: drive ready/scan, then compare outputs with bench expectations and the scoreboard head.
    task automatic cyc(input logic rdy, input logic scan, input logic exp_v,
                       input logic exp_busy, input logic exp_done, input logic exp_cfg);
        pair_t e;
        @(posedge clk);
        #2;
        bus.start     = 1'b0;
        bus.rd_ready  = rdy;
        bus.scan_mode = scan;
        #1;
        check("valid_1", 32'(bus.addr_1_valid_out), 32'(exp_v));
        check("valid_2", 32'(bus.addr_2_valid_out), 32'(exp_v));
        check("busy",    32'(bus.busy), 32'(exp_busy));
        check("done",    32'(bus.done), 32'(exp_done));
        check("cfg_err", 32'(bus.cfg_err), 32'(exp_cfg));
        if (!exp_v) begin
            check("tile_last_invalid", 32'(bus.tile_last_out), 32'd0);
        end else if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q[0];
            check("addr_1",    32'(bus.addr_1_out), 32'(e.a1));
            check("addr_2",    32'(bus.addr_2_out), 32'(e.a2));
            check("tile_idx",  32'(bus.tile_idx_out), 32'(e.tile));
            check("phase",     32'(bus.phase_out), 32'(e.phase));
            check("tile_last", 32'(bus.tile_last_out), 32'(e.last));
            if (rdy) void'(exp_q.pop_front());
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_rows  = '0;
        bus.scan_mode = 1'b0;
        bus.rd_ready  = 1'b0;
        #1;
        check_all_zero("reset");
        #20;
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Full sequence, base 0x10, 8 rows: three tiles, done on cycle 7.
        do_start(8'h10, 8'd8, 1'b0);
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("seq1_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure on cycles 2-3: pair (12,13) held, done on cycle 9.
        do_start(8'h10, 8'd8, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i <= 8; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("seq2_drained", 32'(exp_q.size()), 32'd0);

        // Address wrap: base 0xFE, one tile.
        do_start(8'hFE, 8'd4, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("seq3_drained", 32'(exp_q.size()), 32'd0);

        // Too few rows: single cfg_err pulse, nothing issued.
        do_start(8'h00, 8'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Scan-load for two cycles mid-run: frozen at tile 0 phase 1, then resumes.
        do_start(8'h20, 8'd8, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("scan_hold_phase", 32'(bus.phase_out), 32'd1);
        check("scan_hold_addr",  32'(bus.addr_1_out), 32'h22);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("scan_hold_tile",  32'(bus.tile_idx_out), 32'd0);
        for (int i = 4; i <= 8; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("seq5_drained", 32'(exp_q.size()), 32'd0);

        // Start during scan-load in IDLE is ignored, including a bad row count.
        do_start(8'h40, 8'd8, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_start(8'h40, 8'd3, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-run at tile 1, then a fresh start from tile 0.
        do_start(8'h30, 8'd8, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_reset_tile", 32'(bus.tile_idx_out), 32'd1);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b1;
        do_start(8'h30, 8'd8, 1'b0);
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("seq6_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
